// File: rtl/carregador_programa_pkg.sv
// Shared definitions for the program loader: FSM state encoding and protocol constants.
package carregador_programa_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StLenHi  = 4'd1,
    StLenLo  = 4'd2,
    StDataHi = 4'd3,
    StDataLo = 4'd4,
    StWrite  = 4'd5,
    StCheck  = 4'd6,
    StDone   = 4'd7,
    StError  = 4'd8
  } estado_t;

  localparam int unsigned LarguraPalavra = 16;
  localparam int unsigned PassoEndereco  = 2;

  // States in which the stream interface accepts a byte.
  function automatic logic aceita_byte(input estado_t estado);
    return (estado == StLenHi) || (estado == StLenLo) || (estado == StDataHi) ||
           (estado == StDataLo) || (estado == StCheck);
  endfunction

  // States that belong to an in-progress load.
  function automatic logic em_carga(input estado_t estado);
    return aceita_byte(estado) || (estado == StWrite);
  endfunction

endpackage

// File: rtl/carregador_programa_montador_palavra.sv
// Assembles big-endian byte pairs into a word and keeps the running XOR of data bytes.
module montador_palavra
  import carregador_programa_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      load_hi,
  input  logic                      load_lo,
  input  logic [7:0]                byte_in,
  output logic [LarguraPalavra-1:0] palavra,
  output logic [7:0]                checksum
);

  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] chk_q, chk_d;

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    chk_d = chk_q;
    if (clear) begin
      hi_d  = '0;
      lo_d  = '0;
      chk_d = '0;
    end else if (load_hi) begin
      hi_d  = byte_in;
      chk_d = chk_q ^ byte_in;
    end else if (load_lo) begin
      lo_d  = byte_in;
      chk_d = chk_q ^ byte_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      chk_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      chk_q <= chk_d;
    end
  end

  assign palavra  = {hi_q, lo_q};
  assign checksum = chk_q;

endmodule

// File: rtl/carregador_programa.sv
// Program loader: receives a length-prefixed byte stream, writes 16-bit words into
// instruction memory and holds the processor in reset until the checksum is verified.
module carregador_programa
  import carregador_programa_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE = 16'h0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_escrita,
  output logic [15:0] mem_endereco,
  output logic [15:0] mem_dado,
  output logic        cpu_reset,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro
);

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);
  localparam logic [15:0] Passo    = 16'(PassoEndereco);

  estado_t estado_q, estado_d;
  logic [15:0] endereco_q, endereco_d;
  logic [15:0] len_q, len_d;
  logic [15:0] contador_q, contador_d;
  logic [7:0]  len_hi_q, len_hi_d;

  logic        transfer;
  logic        load_hi, load_lo, limpa;
  logic [15:0] n_rx;
  logic [15:0] contador_inc;
  logic [LarguraPalavra-1:0] palavra;
  logic [7:0]  checksum;

  montador_palavra u_montador (
    .clock    (clock),
    .reset    (reset),
    .clear    (limpa),
    .load_hi  (load_hi),
    .load_lo  (load_lo),
    .byte_in  (byte_in),
    .palavra  (palavra),
    .checksum (checksum)
  );

  assign transfer     = byte_valid & byte_ready;
  assign n_rx         = {len_hi_q, byte_in};
  assign contador_inc = contador_q + 16'd1;

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    len_d      = len_q;
    contador_d = contador_q;
    len_hi_d   = len_hi_q;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    limpa      = 1'b0;

    unique case (estado_q)
      StIdle, StDone, StError: begin
        if (start) begin
          estado_d   = StLenHi;
          endereco_d = ADDR_BASE;
          contador_d = '0;
          limpa      = 1'b1;
        end
      end
      StLenHi: begin
        if (transfer) begin
          len_hi_d = byte_in;
          estado_d = StLenLo;
        end
      end
      StLenLo: begin
        if (transfer) begin
          len_d = n_rx;
          if ({1'b0, n_rx} > MaxWords) begin
            estado_d = StError;
          end else if (n_rx == 16'd0) begin
            estado_d = StCheck;
          end else begin
            estado_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (transfer) begin
          load_hi  = 1'b1;
          estado_d = StDataLo;
        end
      end
      StDataLo: begin
        if (transfer) begin
          load_lo  = 1'b1;
          estado_d = StWrite;
        end
      end
      StWrite: begin
        // Address and counter advance once the strobe cycle is over.
        endereco_d = endereco_q + Passo;
        contador_d = contador_inc;
        estado_d   = (contador_inc == len_q) ? StCheck : StDataHi;
      end
      StCheck: begin
        if (transfer) begin
          estado_d = (byte_in == checksum) ? StDone : StError;
        end
      end
      default: estado_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= StIdle;
      endereco_q <= ADDR_BASE;
      len_q      <= '0;
      contador_q <= '0;
      len_hi_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      len_q      <= len_d;
      contador_q <= contador_d;
      len_hi_q   <= len_hi_d;
    end
  end

  always_comb begin
    byte_ready   = aceita_byte(estado_q);
    mem_escrita  = (estado_q == StWrite);
    mem_endereco = endereco_q;
    mem_dado     = mem_escrita ? palavra : '0;
    ocupado      = em_carga(estado_q);
    // A failed load keeps the processor in reset so a partial image never runs.
    cpu_reset    = ocupado | (estado_q == StError);
    pronto       = (estado_q == StDone);
    erro         = (estado_q == StError);
  end

endmodule
